// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch control between the PC register and decode. Issues one
//   request at a time to instruction memory (req/ack, variable latency), steers
//   the PC register, and queues fetched {instr, pc} pairs in a 2-entry
//   valid/ready buffer toward decode. A redirect flushes the buffer. If a
//   request is still in flight at that point, its response is dropped.
//
//   Optional build macro: FETCH_PERF_EN adds saturating perf counters
//   perf_stall_cycles (cycles spent in HOLD) and perf_drops (discarded
//   responses).
//
// Ports
//   clk, clr            clock (rising edge), async active-low reset
//   pc                  current PC from the PC register
//   pc_next, pc_load    next PC value and load enable for the PC register
//   imem_req/addr       memory request and address
//   imem_ack/rdata      memory response; ack completes the request
//   redirect/_pc        one-cycle flush pulse and its target
//   if_valid/instr/pc   buffer head toward decode
//   id_ready            decode accepts the head when if_valid && id_ready
module fetch_stage #(
  parameter int unsigned N       = 32,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned PC_INC  = 4
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [N-1:0]       pc,
  output logic [N-1:0]       pc_next,
  output logic               pc_load,
  output logic               imem_req,
  output logic [N-1:0]       imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [N-1:0]       redirect_pc,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [N-1:0]       if_pc,
  input  logic               id_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_stall_cycles,
  output logic [31:0]        perf_drops
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;

  state_t             state;
  logic [N-1:0]       addr_q;
  logic [1:0]         count;
  logic [1:0]         count_nx;
  logic [INSTR_W-1:0] instr0, instr1;
  logic [N-1:0]       pc0, pc1;
  logic               push;
  logic               pop;
  logic               wr_slot;

  // Request side depends only on the registered state.
  always_comb begin
    imem_req  = (state == REQ) || (state == DROP);
    imem_addr = (state == REQ) ? pc : addr_q;
  end

  always_comb begin
    pop  = (count != 2'd0) && id_ready;
    push = (state == REQ) && imem_ack && !redirect;
    // After an optional pop shifts slot 1 into slot 0, the new entry lands
    // at index (count - pop).
    wr_slot = (count == 2'd2) || ((count == 2'd1) && !pop);
    if (redirect)
      count_nx = 2'd0;
    else
      count_nx = count + {1'b0, push} - {1'b0, pop};
  end

  // PC register steering is combinational so the new PC lands on the same
  // edge that completes the request; held quiet while reset is asserted.
  always_comb begin
    pc_load = 1'b0;
    pc_next = '0;
    if (clr) begin
      if (redirect) begin
        pc_load = 1'b1;
        pc_next = redirect_pc;
      end else if (push) begin
        pc_load = 1'b1;
        pc_next = pc + N'(PC_INC);
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state  <= IDLE;
      addr_q <= '0;
      count  <= '0;
      instr0 <= '0;
      instr1 <= '0;
      pc0    <= '0;
      pc1    <= '0;
    end else begin
      // A redirect forces count_nx to 0, so "count_nx < 2" also covers the
      // redirect cases for REQ+ack and HOLD.
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (imem_ack)
            state <= (count_nx < 2'd2) ? REQ : HOLD;
          else if (redirect)
            state <= DROP;
        end
        HOLD: begin
          if (count_nx < 2'd2)
            state <= REQ;
        end
        DROP: begin
          if (imem_ack)
            state <= REQ;
        end
      endcase

      // Captured every REQ cycle so DROP can keep presenting the in-flight
      // address after the PC register has moved to the redirect target.
      if (state == REQ)
        addr_q <= pc;

      count <= count_nx;

      if (!redirect) begin
        if (pop) begin
          instr0 <= instr1;
          pc0    <= pc1;
        end
        if (push) begin
          if (wr_slot) begin
            instr1 <= imem_rdata;
            pc1    <= pc;
          end else begin
            instr0 <= imem_rdata;
            pc0    <= pc;
          end
        end
      end
    end
  end

  always_comb begin
    if_valid = (count != 2'd0);
    if_instr = instr0;
    if_pc    = pc0;
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      perf_stall_cycles <= '0;
      perf_drops        <= '0;
    end else begin
      if ((state == HOLD) && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (imem_ack && ((state == DROP) || ((state == REQ) && redirect)) &&
          (perf_drops != '1))
        perf_drops <= perf_drops + 32'd1;
    end
  end
`endif

  // The issue rule (count + outstanding <= 2) makes a push into a full
  // buffer without a matching pop unreachable.
  a_no_overflow: assert property (@(posedge clk) disable iff (!clr)
    !(push && !pop && (count == 2'd2)));

  a_drop_addr_stable: assert property (@(posedge clk) disable iff (!clr)
    ((state == DROP) && !imem_ack) |=> ((state == DROP) && $stable(addr_q)));

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch control stage that sits between the PC register and the decode stage. It drives the PC register's next value and load enable. It issues requests at the current PC to instruction memory over a req/ack handshake with variable latency. Fetched instructions, tagged with their PC, go to decode through a 2-entry valid/ready buffer. It also handles redirect (branch/jump) flushes, including a redirect that arrives while a memory request is still outstanding.

Parameters:
N, 32, PC/address width
INSTR_W, 32, instruction width
PC_INC, 4, sequential PC increment

Ports:
clk  in  1  clock, rising edge
clr  in  1  reset, asynchronous, active-low
pc  in  N  current PC from PC register
pc_next  out  N  next PC value to PC register
pc_load  out  1  PC register load enable
imem_req  out  1  instruction memory request
imem_addr  out  N  request address
imem_ack  in  1  memory response valid; completes request
imem_rdata  in  INSTR_W  instruction data, valid with imem_ack
redirect  in  1  one-cycle flush/redirect pulse
redirect_pc  in  N  redirect target
if_valid  out  1  buffer head valid toward decode
if_instr  out  INSTR_W  head instruction
if_pc  out  N  PC of head instruction
id_ready  in  1  decode accepts head when if_valid && id_ready

Behaviour:
- Reset (clr=0, asynchronous):
  - state=IDLE, buffer empty (count=0).
  - if_valid=0, imem_req=0, pc_load=0.
  - pc_next, if_instr, if_pc, addr_q all =0.
- States: IDLE, REQ, HOLD, DROP.
- IDLE: imem_req=0. Next cycle goes to REQ. Only entered from reset.
- REQ: imem_req=1, imem_addr=pc, addr_q<=pc every cycle. At most one request is outstanding.
  - imem_ack=1 in the same cycle, no redirect:
    - push {imem_rdata, pc} into buffer.
    - pc_load=1, pc_next=pc+PC_INC (mod 2^N, wraps silently).
    - Next state is REQ if post-cycle count + 0 outstanding < 2, else HOLD.
  - No ack: remain in REQ; pc_load=0.
- HOLD: imem_req=0. Go to REQ in the cycle after count drops below 2.
- DROP: imem_req=1, imem_addr=addr_q (address held stable). On imem_ack: discard imem_rdata, go to REQ. Nothing is pushed.
- Redirect (highest priority, any state except IDLE):
  - pc_load=1, pc_next=redirect_pc in the same cycle.
  - Buffer is cleared at the clock edge; if_valid=0 the next cycle. A same-cycle pop is still honoured by decode, but discarded entries are not re-presented.
  - From REQ with no ack this cycle: go to DROP.
  - From REQ with ack this cycle: discard data, go to REQ.
  - From DROP with no ack: stay in DROP. From DROP with ack: go to REQ.
  - From HOLD: go to REQ.
- Redirect in IDLE: pc_load/pc_next still apply; state goes to REQ as normal.
- Buffer: FIFO, head on if_instr/if_pc.
  - Push and pop in the same cycle are legal at any count.
  - Issue rule (count + outstanding ≤ 2) guarantees no push when full. Overflow is impossible by construction; assertion-check it.
- Latency: ack at cycle t → if_valid=1 at t+1 (if the buffer was empty). New pc is visible from the PC register at t+1, and the next request goes out at t+1.
- imem_req stays asserted until imem_ack; the address does not change while req is held without ack in DROP.

Optional Feature:
- FETCH_PERF_EN defined:
  - Adds outputs perf_stall_cycles[31:0] (cycles in HOLD) and perf_drops[31:0] (responses discarded in DROP, or at ack-with-redirect).
  - Both are saturating at 2^32-1 and reset to 0 by clr.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset released with pc=0x0, imem_ack returned 1 cycle after each req, id_ready=1 → imem_addr sequence 0x0,0x4,0x8; if_pc matches the sequence; pc_next=addr+4 with pc_load pulsing on each ack.
- id_ready=0 held, ack every cycle → exactly 2 entries buffered, state HOLD, imem_req=0. Raise id_ready → entries drained in order, fetch resumes at 0x8.
- Redirect to 0x100 while req at 0x10 is outstanding, ack 3 cycles later with 0xDEADBEEF → 0xDEADBEEF never appears on if_instr; imem_addr holds 0x10 until ack; next request goes to 0x100.
- Redirect coinciding with ack → data discarded, buffer cleared, next request at redirect_pc, if_valid=0 the next cycle.
- clr asserted mid-DROP → all outputs reset immediately (asynchronously); after release, fetch restarts from pc.
- pc=0xFFFFFFFC, ack → pc_next=0x00000000; with FETCH_PERF_EN, 5 HOLD cycles → perf_stall_cycles=5.
